// File: rtl/csr_pkg.sv
// Shared constants, state encoding and write-merge helper for the machine-mode CSR/IRQ unit.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS     = 12'h300;
   localparam logic [11:0] CSR_MIE         = 12'h304;
   localparam logic [11:0] CSR_MTVEC       = 12'h305;
   localparam logic [11:0] CSR_MEPC        = 12'h341;
   localparam logic [11:0] CSR_MCAUSE      = 12'h342;
   localparam logic [11:0] CSR_MIP         = 12'h344;
   localparam logic [11:0] CSR_MTIME_LO    = 12'h7C0;
   localparam logic [11:0] CSR_MTIME_HI    = 12'h7C1;
   localparam logic [11:0] CSR_MTIMECMP_LO = 12'h7C2;
   localparam logic [11:0] CSR_MTIMECMP_HI = 12'h7C3;

   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MTIE_BIT = 7;
   localparam int MEIE_BIT = 11;

   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] MIE_WMASK     = 32'h0000_0880;

   typedef enum logic [1:0] {IDLE, TRAP, HANDLER, RETURN} irq_state_e;

   localparam logic [1:0] IRQ_IDLE   = 2'b00;
   localparam logic [1:0] IRQ_ENTRY  = 2'b01;
   localparam logic [1:0] IRQ_ACTIVE = 2'b10;
   localparam logic [1:0] IRQ_MASKED = 2'b11;

   // Zicsr merge: 01 write, 10 set, 11 clear; 00 leaves the value alone.
   function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old_v,
                                             input logic [31:0] wdata);
      case (op)
         2'b01:   csr_apply = wdata;
         2'b10:   csr_apply = old_v | wdata;
         2'b11:   csr_apply = old_v & ~wdata;
         default: csr_apply = old_v;
      endcase
   endfunction

endpackage

// File: rtl/csr_irq_unit_irq_sync.sv
// NUM_IRQ_SYNC-deep flop chain bringing one asynchronous interrupt level into the clk domain.
module irq_sync #(
   parameter int NUM_IRQ_SYNC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [NUM_IRQ_SYNC-1:0] sync_q, sync_d;

   always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < NUM_IRQ_SYNC; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
   end

   assign q = sync_q[NUM_IRQ_SYNC-1];

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and interrupt/mret sequencer in the MW stage.
// Define CSR_TIMER_EN to add internal mtime/mtimecmp (0x7C0-0x7C3) driving MTIP.
module csr_irq_unit
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RST    = 32'h0000_0000,
   parameter int          NUM_IRQ_SYNC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_rd,
   input  logic        csr_wr,
   input  logic [11:0] csr_addr,
   input  logic [1:0]  csr_op,
   input  logic [31:0] csr_wdata,
   input  logic [31:0] pc_mw,
   input  logic        is_mret,
   input  logic        timer_irq,
   input  logic        ext_irq,
   output logic [31:0] csr_rdata,
   output logic [1:0]  interrupt,
   output logic        epc_taken,
   output logic [31:0] redirect_pc
);

   irq_state_e  state_q, state_d;
   logic [3:0]  cause_q, cause_d;
   logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
   logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
   logic        meip, mtip;
   logic [31:0] mip, irq_act, rd_val, new_v, vec_base;
   logic        pend, wr_en;

   irq_sync #(.NUM_IRQ_SYNC(NUM_IRQ_SYNC)) u_sync_ext (
      .clk(clk), .rst(rst), .d(ext_irq), .q(meip)
   );

`ifdef CSR_TIMER_EN
   logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic        unused_timer_irq;

   assign unused_timer_irq = timer_irq;
   assign mtip = (mtime_q >= mtimecmp_q);

   // Halves written independently; the free-running increment carries across the full 64 bits.
   always_comb begin
      mtime_d    = mtime_q + 64'd1;
      mtimecmp_d = mtimecmp_q;
      if (wr_en) begin
         case (csr_addr)
            CSR_MTIME_LO:    mtime_d[31:0]     = new_v;
            CSR_MTIME_HI:    mtime_d[63:32]    = new_v;
            CSR_MTIMECMP_LO: mtimecmp_d[31:0]  = new_v;
            CSR_MTIMECMP_HI: mtimecmp_d[63:32] = new_v;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
      end
   end
`else
   irq_sync #(.NUM_IRQ_SYNC(NUM_IRQ_SYNC)) u_sync_tmr (
      .clk(clk), .rst(rst), .d(timer_irq), .q(mtip)
   );
`endif

   always_comb begin
      mip           = '0;
      mip[MEIE_BIT] = meip;
      mip[MTIE_BIT] = mtip;
   end

   assign irq_act = mie_q & mip;
   assign pend    = mstatus_q[MIE_BIT] & (|irq_act);

   always_comb begin
      rd_val = '0;
      case (csr_addr)
         CSR_MSTATUS:     rd_val = mstatus_q;
         CSR_MIE:         rd_val = mie_q;
         CSR_MTVEC:       rd_val = mtvec_q;
         CSR_MEPC:        rd_val = {mepc_q[31:2], 2'b00};
         CSR_MCAUSE:      rd_val = mcause_q;
         CSR_MIP:         rd_val = mip;
`ifdef CSR_TIMER_EN
         CSR_MTIME_LO:    rd_val = mtime_q[31:0];
         CSR_MTIME_HI:    rd_val = mtime_q[63:32];
         CSR_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
         CSR_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
`endif
         default:         rd_val = '0;
      endcase
   end

   assign csr_rdata = (csr_rd && !rst) ? rd_val : '0;
   assign new_v     = csr_apply(csr_op, rd_val, csr_wdata);
   // The instruction in MW during TRAP is replayed after the handler, so its write is dropped.
   assign wr_en     = csr_wr && (csr_op != 2'b00) && (state_q != TRAP);
   assign vec_base  = {mtvec_q[31:2], 2'b00};

   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      mstatus_d   = mstatus_q;
      mie_d       = mie_q;
      mtvec_d     = mtvec_q;
      mepc_d      = mepc_q;
      mcause_d    = mcause_q;
      interrupt   = IRQ_IDLE;
      epc_taken   = 1'b0;
      redirect_pc = '0;

      if (wr_en) begin
         case (csr_addr)
            CSR_MSTATUS: mstatus_d = (mstatus_q & ~MSTATUS_WMASK) | (new_v & MSTATUS_WMASK);
            CSR_MIE:     mie_d     = (mie_q & ~MIE_WMASK) | (new_v & MIE_WMASK);
            CSR_MTVEC:   mtvec_d   = new_v;
            CSR_MEPC:    mepc_d    = {new_v[31:2], 2'b00};
            CSR_MCAUSE:  mcause_d  = new_v;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (is_mret) begin
               state_d = RETURN;
            end else if (pend) begin
               state_d = TRAP;
               cause_d = irq_act[MEIE_BIT] ? CAUSE_MEI : CAUSE_MTI;
            end else if (|irq_act) begin
               interrupt = IRQ_MASKED;
            end
         end
         TRAP: begin
            interrupt   = IRQ_ENTRY;
            epc_taken   = 1'b1;
            redirect_pc = (mtvec_q[1:0] == 2'b01) ? vec_base + {26'b0, cause_q, 2'b00} : vec_base;
            mepc_d      = {pc_mw[31:2], 2'b00};
            mcause_d    = {1'b1, 27'b0, cause_q};
            mstatus_d[MPIE_BIT] = mstatus_q[MIE_BIT];
            mstatus_d[MIE_BIT]  = 1'b0;
            state_d     = HANDLER;
         end
         HANDLER: begin
            interrupt = IRQ_ACTIVE;
            if (is_mret) state_d = RETURN;
         end
         RETURN: begin
            epc_taken   = 1'b1;
            redirect_pc = {mepc_q[31:2], 2'b00};
            mstatus_d[MIE_BIT]  = mstatus_q[MPIE_BIT];
            mstatus_d[MPIE_BIT] = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cause_q   <= '0;
         mstatus_q <= '0;
         mie_q     <= '0;
         mtvec_q   <= MTVEC_RST;
         mepc_q    <= '0;
         mcause_q  <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         mstatus_q <= mstatus_d;
         mie_q     <= mie_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
      end
   end

endmodule
